// File: rtl/seq_multiplier_unit_if.sv
// Start/busy/done handshake and operand/result bus for seq_multiplier_unit.
// The slave modport is the multiplier side; the master modport is the control side.
interface seq_multiplier_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, opA, opB,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, opA, opB,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_multiplier_unit.sv
// Multi-cycle shift-and-add multiplier (MULTU, or MULT when MULT_SIGNED_EN is defined).
// Takes WIDTH iterations per product and writes the 2*WIDTH result into hi/lo.
module seq_multiplier_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  seq_multiplier_unit_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_shift;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  assign a_mag    = bus.opA[WIDTH-1] ? (~bus.opA + WIDTH'(1)) : bus.opA;
  assign b_mag    = bus.opB[WIDTH-1] ? (~bus.opB + WIDTH'(1)) : bus.opB;
  assign prod_fin = sign_q ? (~acc_shift + (2*WIDTH)'(1)) : acc_shift;
`else
  assign a_mag    = bus.opA;
  assign b_mag    = bus.opB;
  assign prod_fin = acc_shift;
`endif

  // Carry-out of the upper-half add becomes the new MSB after the shift.
  assign sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (mplier_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
  assign acc_shift = {sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULT_SIGNED_EN
    sign_d   = sign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MULT_SIGNED_EN
          sign_d   = bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1];
`endif
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          {hi_d, lo_d} = prod_fin;
          cnt_d        = '0;
          state_d      = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier_unit.sv
// Self-checking bench for seq_multiplier_unit: expected products are queued at
// start and compared when done pulses, together with latency and busy length.
module tb_seq_multiplier_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_multiplier_unit_if #(.WIDTH(W)) bus ();

  seq_multiplier_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] sb[$];

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [2*W-1:0] sa, sbv;
    sa  = $signed({{W{a[W-1]}}, a});
    sbv = $signed({{W{b[W-1]}}, b});
    return sa * sbv;
`else
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
  endfunction

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = a;
    bus.opB   = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // mode 1: inject an ignored start at cycle 10 and scramble operands from cycle 15
  task automatic wait_done(input int mode, output int lat, output int busy_n,
                           output logic [2*W-1:0] prod);
    lat    = -1;
    busy_n = 0;
    prod   = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mode == 1) begin
        if (c == 10) begin
          bus.start = 1'b1;
          bus.opA   = 7;
          bus.opB   = 7;
        end else if (c == 11) begin
          bus.start = 1'b0;
        end
        if (c >= 15) begin
          bus.opA = $urandom;
          bus.opB = $urandom;
        end
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat  = c;
        prod = {bus.hi, bus.lo};
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.hi !== '0) begin fails++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    tests++; if (bus.lo !== '0) begin fails++; $display("FAIL reset_lo got %h want 0", bus.lo); end
  endtask

  task automatic test_basic;
    int lat, busy_n;
    logic [2*W-1:0] prod, exp;
    do_start(3, 5);
    wait_done(0, lat, busy_n, prod);
    exp = sb.pop_front();
    tests++; if (lat !== 33) begin fails++; $display("FAIL basic_latency got %0d want 33", lat); end
    tests++; if (busy_n !== 32) begin fails++; $display("FAIL basic_busy got %0d want 32", busy_n); end
    tests++; if (prod !== exp) begin fails++; $display("FAIL basic_prod got %h want %h", prod, exp); end
    tests++; if (prod !== 64'h0000_0000_0000_000F) begin
      fails++; $display("FAIL basic_const got %h want 000000000000000f", prod);
    end
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_pulse got %b want 0", bus.done); end
    tests++; if ({bus.hi, bus.lo} !== exp) begin
      fails++; $display("FAIL hold_result got %h want %h", {bus.hi, bus.lo}, exp);
    end
  endtask

  task automatic test_arith;
    logic [W-1:0] av[3];
    logic [W-1:0] bv[3];
    logic [2*W-1:0] cv[3];
    int lat, busy_n;
    logic [2*W-1:0] prod, exp;
`ifdef MULT_SIGNED_EN
    av = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000};
    bv = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000};
    cv = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000};
`else
    av = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
    bv = '{32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000};
    cv = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0002_FFFF_FFFA, 64'h4000_0000_0000_0000};
`endif
    for (int i = 0; i < 3; i++) begin
      do_start(av[i], bv[i]);
      wait_done(0, lat, busy_n, prod);
      exp = sb.pop_front();
      tests++; if (lat !== 33) begin fails++; $display("FAIL arith%0d_latency got %0d want 33", i, lat); end
      tests++; if (prod !== exp) begin fails++; $display("FAIL arith%0d_prod got %h want %h", i, prod, exp); end
      tests++; if (prod !== cv[i]) begin fails++; $display("FAIL arith%0d_const got %h want %h", i, prod, cv[i]); end
    end
  endtask

  task automatic test_ignore_start;
    int lat, busy_n;
    logic [2*W-1:0] prod, exp;
    do_start(3, 5);
    wait_done(1, lat, busy_n, prod);
    exp = sb.pop_front();
    tests++; if (lat !== 33) begin fails++; $display("FAIL ignore_latency got %0d want 33", lat); end
    tests++; if (busy_n !== 32) begin fails++; $display("FAIL ignore_busy got %0d want 32", busy_n); end
    tests++; if (prod !== exp) begin fails++; $display("FAIL ignore_prod got %h want %h", prod, exp); end
  endtask

  task automatic test_reset_abort;
    int lat, busy_n;
    logic [2*W-1:0] prod, exp;
    do_start(32'h0000_FFFF, 32'h0000_FFFF);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", bus.done); end
    tests++; if ({bus.hi, bus.lo} !== '0) begin
      fails++; $display("FAIL abort_hilo got %h want 0", {bus.hi, bus.lo});
    end
    do_start(2, 2);
    wait_done(0, lat, busy_n, prod);
    exp = sb.pop_front();
    tests++; if (lat !== 33) begin fails++; $display("FAIL after_abort_latency got %0d want 33", lat); end
    tests++; if (prod !== exp) begin fails++; $display("FAIL after_abort_prod got %h want %h", prod, exp); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av[3];
    logic [W-1:0] bv[3];
    int lat, busy_n;
    logic [2*W-1:0] prod, exp;
    av = '{32'h0000_0000, 32'h0000_0009, 32'h1234_5678};
    bv = '{32'h1234_5678, 32'h0000_000B, 32'h9ABC_DEF0};
    for (int i = 0; i < 3; i++) begin
      do_start(av[i], bv[i]);
      wait_done(0, lat, busy_n, prod);
      exp = sb.pop_front();
      tests++; if (lat !== 33) begin fails++; $display("FAIL b2b%0d_latency got %0d want 33", i, lat); end
      tests++; if (busy_n !== 32) begin fails++; $display("FAIL b2b%0d_busy got %0d want 32", i, busy_n); end
      tests++; if (prod !== exp) begin fails++; $display("FAIL b2b%0d_prod got %h want %h", i, prod, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    tests++; if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
